// File: rtl/lmsm_uop_sequencer_if.sv
// rtl/lmsm_uop_sequencer_if.sv - decode-stage LM/SM sequencer bus
interface lmsm_uop_sequencer_if;
  logic [15:0] ir;
  logic        ir_valid;
  logic        hold;
  logic        busy;
  logic        uop_valid;
  logic [15:0] uop_ir;
  logic [2:0]  uop_reg;
  logic [2:0]  uop_offset;
  logic        uop_first;
  logic        uop_last;

  // Upstream/downstream pipeline control side
  modport master (
    output ir, ir_valid, hold,
    input  busy, uop_valid, uop_ir, uop_reg, uop_offset, uop_first, uop_last
  );

  // Sequencer side
  modport slave (
    input  ir, ir_valid, hold,
    output busy, uop_valid, uop_ir, uop_reg, uop_offset, uop_first, uop_last
  );
endinterface

// File: rtl/lmsm_uop_sequencer.sv
// rtl/lmsm_uop_sequencer.sv - expands multi-register LM/SM into single-register micro-ops
module lmsm_uop_sequencer (
  input  logic                   clk,
  input  logic                   rst,
  lmsm_uop_sequencer_if.slave    bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEQ  = 1'b1;

  logic [0:0]  state;
  logic [7:0]  rem_mask;
  logic [15:0] cur_ir;
  logic [2:0]  cnt;

  // Index of the lowest set bit; 0 for an empty mask
  function automatic logic [2:0] lsb(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = i[2:0];
    end
    return r;
  endfunction

  logic        in_lmsm;
  logic        in_multi;
  logic [2:0]  in_idx;
  logic [7:0]  in_onehot;
  logic [7:0]  in_rest;
  logic [2:0]  seq_idx;
  logic [7:0]  seq_onehot;
  logic [7:0]  seq_rest;

  assign in_lmsm    = (bus.ir[15:12] == 4'b0110) || (bus.ir[15:12] == 4'b0111);
  // Two or more bits set: clearing the lowest bit still leaves something
  assign in_multi   = in_lmsm && ((bus.ir[7:0] & (bus.ir[7:0] - 8'd1)) != 8'd0);
  assign in_idx     = lsb(bus.ir[7:0]);
  assign in_onehot  = 8'd1 << in_idx;
  assign in_rest    = bus.ir[7:0] & ~in_onehot;
  assign seq_idx    = lsb(rem_mask);
  assign seq_onehot = 8'd1 << seq_idx;
  assign seq_rest   = rem_mask & ~seq_onehot;

  // Sequencer state and registered micro-op outputs; hold freezes everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      rem_mask       <= 8'd0;
      cur_ir         <= 16'd0;
      cnt            <= 3'd0;
      bus.busy       <= 1'b0;
      bus.uop_valid  <= 1'b0;
      bus.uop_ir     <= 16'd0;
      bus.uop_reg    <= 3'd0;
      bus.uop_offset <= 3'd0;
      bus.uop_first  <= 1'b0;
      bus.uop_last   <= 1'b0;
    end else if (!bus.hold) begin
      case (state)
        IDLE: begin
          if (!bus.ir_valid) begin
            bus.uop_valid <= 1'b0;
          end else if (!in_multi) begin
            // Zero and single-bit masks already are a valid one-hot (or no-op) form
            bus.uop_valid  <= 1'b1;
            bus.uop_ir     <= bus.ir;
            bus.uop_reg    <= in_lmsm ? in_idx : 3'd0;
            bus.uop_offset <= 3'd0;
            bus.uop_first  <= 1'b1;
            bus.uop_last   <= 1'b1;
          end else begin
            bus.uop_valid  <= 1'b1;
            bus.uop_ir     <= {bus.ir[15:8], in_onehot};
            bus.uop_reg    <= in_idx;
            bus.uop_offset <= 3'd0;
            bus.uop_first  <= 1'b1;
            bus.uop_last   <= 1'b0;
            rem_mask       <= in_rest;
            cur_ir         <= bus.ir;
            cnt            <= 3'd1;
            bus.busy       <= 1'b1;
            state          <= SEQ;
          end
        end
        default: begin
          // The selected bit is always a member of the original mask
          bus.uop_valid  <= 1'b1;
          bus.uop_ir     <= {cur_ir[15:8], seq_onehot & cur_ir[7:0]};
          bus.uop_reg    <= seq_idx;
          bus.uop_offset <= cnt;
          bus.uop_first  <= 1'b0;
          rem_mask       <= seq_rest;
          cnt            <= cnt + 3'd1;
          if (seq_rest == 8'd0) begin
            bus.uop_last <= 1'b1;
            bus.busy     <= 1'b0;
            state        <= IDLE;
          end else begin
            bus.uop_last <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lmsm_uop_sequencer.sv
// tb/tb_lmsm_uop_sequencer.sv - directed self-checking bench for lmsm_uop_sequencer
module tb_lmsm_uop_sequencer;
  logic clk;
  logic rst;
  int   total;
  int   bad;

  lmsm_uop_sequencer_if bus ();

  lmsm_uop_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle so outputs reflect that edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_uop(input string tag, input logic [15:0] e_ir, input logic [2:0] e_reg,
                           input logic [2:0] e_off, input logic e_first, input logic e_last,
                           input logic e_busy, input logic e_valid);
    chk({tag, ".ir"},    {16'd0, bus.uop_ir},       {16'd0, e_ir});
    chk({tag, ".reg"},   {29'd0, bus.uop_reg},      {29'd0, e_reg});
    chk({tag, ".off"},   {29'd0, bus.uop_offset},   {29'd0, e_off});
    chk({tag, ".first"}, {31'd0, bus.uop_first},    {31'd0, e_first});
    chk({tag, ".last"},  {31'd0, bus.uop_last},     {31'd0, e_last});
    chk({tag, ".busy"},  {31'd0, bus.busy},         {31'd0, e_busy});
    chk({tag, ".valid"}, {31'd0, bus.uop_valid},    {31'd0, e_valid});
  endtask

  logic [2:0] regs4 [4];
  logic [7:0] low4  [4];

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    bus.ir = 16'h0000;
    bus.ir_valid = 1'b0;
    bus.hold = 1'b0;
    tick();
    tick();
    check_uop("reset", 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // ADD pass-through, then an idle cycle drops valid but keeps data
    bus.ir = 16'h1234; bus.ir_valid = 1'b1;
    tick();
    check_uop("add", 16'h1234, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    bus.ir_valid = 1'b0;
    tick();
    check_uop("idle", 16'h1234, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Single-bit and zero masks
    bus.ir = 16'h6A10; bus.ir_valid = 1'b1;
    tick();
    check_uop("lm1", 16'h6A10, 3'd4, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);
    bus.ir = 16'h7200;
    tick();
    check_uop("sm0", 16'h7200, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Four-bit expansion with garbage upstream during SEQ
    regs4 = '{3'd1, 3'd2, 3'd5, 3'd7};
    low4  = '{8'h02, 8'h04, 8'h20, 8'h80};
    bus.ir = 16'h64A6; bus.ir_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_uop($sformatf("lm4_%0d", i), {8'h64, low4[i]}, regs4[i], i[2:0],
                i == 0, i == 3, i != 3, 1'b1);
      bus.ir = 16'h7FFF ^ 16'(i);
      bus.ir_valid = i[0];
    end
    bus.ir = 16'h2345; bus.ir_valid = 1'b1;
    tick();
    check_uop("after4", 16'h2345, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);

    // Full mask with two held cycles after the third micro-op
    bus.ir = 16'h70FF;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_uop($sformatf("sm8_%0d", i), {8'h70, 8'h01 << i}, i[2:0], i[2:0],
                i == 0, i == 7, i != 7, 1'b1);
      bus.ir = 16'h1111;
      if (i == 2) begin
        bus.hold = 1'b1;
        for (int h = 0; h < 2; h++) begin
          tick();
          check_uop($sformatf("hold_%0d", h), 16'h7004, 3'd2, 3'd2, 1'b0, 1'b0, 1'b1, 1'b1);
        end
        bus.hold = 1'b0;
      end
    end
    bus.ir_valid = 1'b0;
    tick();
    chk("sm8_done.valid", {31'd0, bus.uop_valid}, 32'd0);

    // Reset mid-SEQ, with hold also high on the second reset cycle
    bus.ir = 16'h64A6; bus.ir_valid = 1'b1;
    tick();
    tick();
    check_uop("pre_rst", 16'h6404, 3'd2, 3'd1, 1'b0, 1'b0, 1'b1, 1'b1);
    rst = 1'b1;
    tick();
    bus.hold = 1'b1;
    tick();
    check_uop("mid_rst", 16'h0000, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0; bus.hold = 1'b0;
    bus.ir = 16'h1234; bus.ir_valid = 1'b1;
    tick();
    check_uop("post_rst", 16'h1234, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lmsm_uop_sequencer.md
# lmsm_uop_sequencer

Decode-stage sequencer for the load-multiple/store-multiple instructions (opcodes 0110 LM, 0111 SM). It sits directly downstream of the IR mux/stall control. It accepts one instruction per cycle from the IF/ID register. Any LM/SM whose 8-bit register mask has two or more bits set is expanded into a stream of single-register micro-ops, one per cycle. Meanwhile `busy` stalls fetch and the IF/ID register. Each micro-op carries a one-hot mask, so downstream stall logic sees it as a non-stalling instruction.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  reset: synchronous, active-high.
- `ir`  in  16  instruction from IF/ID: [15:12] opcode, [11:9] RA base register, [7:0] register mask.
- `ir_valid`  in  1  `ir` holds a real instruction.
- `hold`  in  1  downstream freeze; while high, the block's state and all outputs are unchanged.
- `busy`  out  1  registered; high while a multi-register expansion is in progress. Fetch and IF/ID must hold.
- `uop_valid`  out  1  micro-op outputs are valid this cycle.
- `uop_ir`  out  16  the instruction with [7:0] replaced by the one-hot mask of `uop_reg`. Non-LM/SM instructions pass through unchanged.
- `uop_reg`  out  3  register index of this transfer; 0 for non-LM/SM or a zero mask.
- `uop_offset`  out  3  number of micro-ops already emitted for this instruction; the memory address is RA + offset.
- `uop_first`  out  1  first micro-op of an instruction.
- `uop_last`  out  1  last micro-op of an instruction.

## Operation
- States: IDLE and SEQ. Registers: `state`, `rem_mask`[7:0], `cur_ir`[15:0], `cnt`[2:0], plus all outputs.
- `multi` = (ir[15:12] == 0110 or 0111) and popcount(ir[7:0]) ≥ 2.
- `lsb(m)` = index of the lowest set bit of m. `clr(m)` = m with that bit cleared.
- **hold = 1:** nothing changes, in any state.
- **IDLE, hold = 0, `ir_valid` = 0:** `uop_valid` ← 0; other outputs keep their values.
- **IDLE, hold = 0, `ir_valid` = 1, not `multi`:** emit a single micro-op.
  - `uop_ir` ← ir, `uop_valid` ← 1, `uop_offset` ← 0, `uop_first` ← 1, `uop_last` ← 1.
  - LM/SM with one bit set: `uop_reg` ← lsb(mask).
  - LM/SM with mask 0: passed through with `uop_reg` ← 0 and mask 0; downstream treats it as a no-op.
  - Any other opcode: `uop_reg` ← 0.
  - Stay in IDLE.
- **IDLE, hold = 0, `ir_valid` = 1, `multi`:** start an expansion.
  - Emit a micro-op for `lsb(mask)`: offset 0, first = 1, last = 0.
  - `rem_mask` ← clr(mask), `cur_ir` ← ir, `cnt` ← 1.
  - Go to SEQ; `busy` ← 1.
- **SEQ, hold = 0:** emit the next micro-op.
  - `uop_reg` ← lsb(rem_mask), `uop_ir` ← `cur_ir` with one-hot mask, `uop_offset` ← `cnt`, first = 0.
  - `rem_mask` ← clr(rem_mask), `cnt` ← `cnt` + 1.
  - If clr(rem_mask) == 0: `uop_last` ← 1, go to IDLE, `busy` ← 0.
  - `ir` and `ir_valid` are ignored in SEQ; upstream keeps the next instruction stable because `busy` is high.
- Register order is always ascending index (R0 first). Offsets are contiguous 0 to k−1 for a mask with k bits set.
- Width rule: `cnt` never exceeds 7, since at most 8 micro-ops are emitted (k ≤ 8).

## Timing
- Latency: 1 cycle from acceptance (rising edge with IDLE, `ir_valid`, !hold) to the first micro-op appearing on the outputs.
- A `multi` instruction with k set bits yields k micro-ops on k consecutive unheld cycles.
- `busy` is high for exactly k−1 unheld cycles, starting the cycle after acceptance. It falls on the same edge that registers the micro-op with `uop_last` = 1.
- The next instruction is accepted on the edge after `busy` falls, giving a back-to-back stream with no bubble.
- `hold` cycles stretch the sequence; every output is stable for their duration.
- Reset values: `busy` = 0, `uop_valid` = 0, `uop_ir` = 0, `uop_reg` = 0, `uop_offset` = 0, `uop_first` = 0, `uop_last` = 0; state IDLE, `rem_mask` = 0, `cnt` = 0.
- Reset mid-SEQ aborts the expansion; remaining micro-ops are discarded.
- `rst` and `hold` both high: reset wins.

## Test plan
- **Reset:** assert `rst` for 2 cycles during SEQ → all outputs 0, `busy` 0; the next valid ADD passes through one cycle later.
- **Non-LM/SM pass-through:** ADD 0x1234 (valid) → next cycle `uop_ir` = 0x1234, valid = 1, first = last = 1, `busy` stays 0.
- **Single-bit and zero masks:** LM 0x6A10 → one micro-op, `uop_reg` = 4, last = 1, `busy` 0. SM 0x7200 → one micro-op, `uop_reg` = 0, mask 0, `busy` 0.
- **Four-bit expansion:** LM 0x64A6 (mask 1010_0110) → regs 1, 2, 5, 7 on consecutive cycles.
  - Offsets 0, 1, 2, 3.
  - `uop_ir` low bytes 0x02, 0x04, 0x20, 0x80.
  - first only on the first micro-op, last only on the fourth.
  - `busy` high for exactly 3 cycles; the following instruction emerges the cycle after the last micro-op.
- **Full mask with hold:** SM 0x70FF with `hold` pulsed for 2 cycles after the 3rd micro-op → 8 micro-ops, regs 0 to 7, offsets 0 to 7; outputs frozen during hold; `busy` high for 7 unheld cycles plus the 2 held cycles.
- **Upstream stability:** during SEQ, change `ir` to garbage and toggle `ir_valid` → the micro-op stream is unaffected.
